gsim_result_packer: RTL and testbench

GSIM_RESULT_PACKER -- requirements
Module: gsim_result_packer

---
 rtl/gsim_pack_pkg.sv | 33 +++
 rtl/gsim_pack_fifo.sv | 70 +++++++
 rtl/gsim_result_packer.sv | 183 ++++++++++++++++++
 tb/tb_gsim_result_packer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pack_pkg.sv
// ---------------------------------------------------------------------------
// gsim_pack_pkg
// Shared types and constants for the GSIM result packer.
//   state_t      : packer FSM states (S_IDLE, S_COLLECT, S_FLUSH)
//   fifo_entry_t : one output FIFO entry {data, index, last}
//   frame_last_idx(): index of the final word of a frame for a given mode
// ---------------------------------------------------------------------------
package gsim_pack_pkg;

    localparam int WORD_W          = 24;
    localparam int BYTE_W          = 8;
    localparam int FIFO_DEPTH      = 8;
    localparam int FRAME_LEN_SOLVE = 8;
    localparam int FRAME_LEN_INV   = 64;
    localparam int IDX_W           = 6;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [IDX_W-1:0]  index;
        logic              last;
    } fifo_entry_t;

    function automatic logic [IDX_W-1:0] frame_last_idx(input logic inv_mode);
        return inv_mode ? IDX_W'(FRAME_LEN_INV - 1) : IDX_W'(FRAME_LEN_SOLVE - 1);
    endfunction

endpackage

// File: rtl/gsim_pack_fifo.sv
// ---------------------------------------------------------------------------
// gsim_pack_fifo
// Synchronous FIFO_DEPTH-entry FIFO of fifo_entry_t with simultaneous
// push/pop. A push while full is accepted only if a pop happens in the same
// cycle; otherwise it is ignored (the caller accounts for the drop).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push       : write wr_entry
//   wr_entry   : entry to write
//   pop        : remove head entry (ignored when empty)
//   head       : current head entry (meaningful only when !empty)
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module gsim_pack_fifo
    import gsim_pack_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t wr_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    fifo_entry_t      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage carries data only; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gsim_result_packer.sv
// ---------------------------------------------------------------------------
// gsim_result_packer
// Packs the solver byte stream (MSB-first) into 24-bit result words, tags
// each word with its index within the frame and a last flag, and queues the
// words in an 8-entry FIFO for a ready/valid consumer. Words that find the
// FIFO full are dropped and flagged with the sticky o_ovf.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   mode       : 0 = 8-word frames, 1 = 64-word frames (latched per frame)
//   in_valid   : in_data carries a byte (always accepted)
//   in_data    : solver byte
//   o_valid    : FIFO head present on o_data/o_index/o_last
//   i_ready    : consumer accepts the head word
//   o_data     : assembled word {b0,b1,b2}
//   o_index    : word position within its frame
//   o_last     : final word of the frame
//   o_ovf      : sticky, at least one word dropped
//   o_ovf_cnt  : dropped-word count, saturating at 255
//                (only when GSIM_PACK_OVF_CNT_EN is defined)
// ---------------------------------------------------------------------------
module gsim_result_packer
    import gsim_pack_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WORD_W-1:0] o_data,
    output logic [IDX_W-1:0]  o_index,
    output logic              o_last,
    output logic              o_ovf
`ifdef GSIM_PACK_OVF_CNT_EN
    ,
    output logic [7:0]        o_ovf_cnt
`endif
);

    state_t              state;
    state_t              state_nx;
    logic [1:0]          byte_cnt;
    logic [2*BYTE_W-1:0] part;
    logic                frame_open;
    logic                frame_open_nx;
    logic                mode_lat;
    logic [IDX_W-1:0]    idx;

    logic                first_byte;
    logic                word_done;
    logic                last_word;

    logic [WORD_W-1:0]   word_p1;
    logic [IDX_W-1:0]    idx_p1;
    logic                last_p1;
    logic                vld_p1;

    fifo_entry_t         wr_entry;
    fifo_entry_t         head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                drop;

    // ---- stage 0: byte assembly, frame tracking, FSM ----
    // frame_open spans from the first byte of a frame to the byte that
    // completes its last word; a byte seen while it is low opens a new frame
    // (from S_IDLE, or early while the previous frame is still draining).
    assign first_byte    = in_valid && !frame_open;
    assign word_done     = in_valid && (byte_cnt == 2'd2);
    assign last_word     = word_done && (idx == frame_last_idx(mode_lat));
    assign frame_open_nx = last_word ? 1'b0 : (first_byte ? 1'b1 : frame_open);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nx = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (last_word) begin
                    state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Drained means nothing queued and nothing in the push stage.
                if (fifo_empty && !vld_p1 && !last_word) begin
                    state_nx = frame_open_nx ? S_COLLECT : S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            frame_open <= 1'b0;
            mode_lat   <= 1'b0;
            idx        <= '0;
        end else begin
            state      <= state_nx;
            frame_open <= frame_open_nx;
            if (first_byte) begin
                mode_lat <= mode;
            end
            if (in_valid) begin
                byte_cnt <= word_done ? 2'd0 : byte_cnt + 2'd1;
            end
            // Index advances on completion, not on push, so drops keep o_last aligned.
            if (word_done) begin
                idx <= last_word ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && !word_done) begin
            part <= {part[BYTE_W-1:0], in_data};
        end
    end

    // ---- stage 1: completed word registered, pushed to the FIFO ----
    always_ff @(posedge clk) begin
        if (word_done) begin
            word_p1 <= {part, in_data};
            idx_p1  <= idx;
            last_p1 <= last_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= word_done;
        end
    end

    assign wr_entry = '{data: word_p1, index: idx_p1, last: last_p1};
    assign pop      = !fifo_empty && i_ready;
    assign drop     = vld_p1 && fifo_full && !pop;

    gsim_pack_fifo u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (vld_p1),
        .wr_entry (wr_entry),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_ovf <= 1'b0;
        end else if (drop) begin
            o_ovf <= 1'b1;
        end
    end

`ifdef GSIM_PACK_OVF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_ovf_cnt <= '0;
        end else if (drop && (o_ovf_cnt != 8'hFF)) begin
            o_ovf_cnt <= o_ovf_cnt + 8'd1;
        end
    end
`endif

    // ---- output: FIFO head, forced to zero while empty ----
    assign o_valid = !fifo_empty;
    assign o_data  = fifo_empty ? '0 : head.data;
    assign o_index = fifo_empty ? '0 : head.index;
    assign o_last  = fifo_empty ? 1'b0 : head.last;

endmodule

// File: tb/tb_gsim_result_packer.sv
// ---------------------------------------------------------------------------
// tb_gsim_result_packer
// Scoreboard bench for gsim_result_packer: a frame model fed by the byte
// driver predicts every word that should reach the FIFO; a negedge monitor
// pops and compares on each accepted output word.
// Define GSIM_PACK_OVF_CNT_EN to also exercise o_ovf_cnt.
// ---------------------------------------------------------------------------
module tb_gsim_result_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        o_valid;
    logic        i_ready;
    logic [23:0] o_data;
    logic [5:0]  o_index;
    logic        o_last;
    logic        o_ovf;
`ifdef GSIM_PACK_OVF_CNT_EN
    logic [7:0]  o_ovf_cnt;
`endif

    gsim_result_packer dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .in_valid (in_valid),
        .in_data  (in_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_index  (o_index),
        .o_last   (o_last),
        .o_ovf    (o_ovf)
`ifdef GSIM_PACK_OVF_CNT_EN
        ,
        .o_ovf_cnt(o_ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected entries: {data[23:0], index[5:0], last}
    logic [30:0] exp_q[$];
    logic [30:0] exp_e;

    // Frame model state
    int          tb_bcnt = 0;
    int          tb_idx  = 0;
    int          tb_wcnt = 0;
    int          drop_lo = -1;
    int          drop_hi = -2;
    bit          tb_open = 1'b0;
    bit          tb_mode = 1'b0;
    logic [15:0] tb_part = '0;

    task automatic send_byte(input logic [7:0] b);
        logic [23:0] w;
        bit          l;
        int          last_idx;
        in_valid = 1'b1;
        in_data  = b;
        if (!tb_open) begin
            tb_open = 1'b1;
            tb_mode = mode;
        end
        if (tb_bcnt == 2) begin
            w        = {tb_part, b};
            last_idx = tb_mode ? 63 : 7;
            l        = (tb_idx == last_idx);
            if (!(tb_wcnt >= drop_lo && tb_wcnt <= drop_hi)) begin
                exp_q.push_back({w, 6'(tb_idx), l});
            end
            tb_wcnt++;
            tb_idx  = l ? 0 : tb_idx + 1;
            tb_bcnt = 0;
            if (l) tb_open = 1'b0;
        end else begin
            tb_part = {tb_part[7:0], b};
            tb_bcnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        bit done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !o_valid) done = 1'b1;
        end
        check_val(tag, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check_val("rst_valid", 32'(o_valid), 32'd0);
        check_val("rst_data",  32'(o_data),  32'd0);
        check_val("rst_index", 32'(o_index), 32'd0);
        check_val("rst_last",  32'(o_last),  32'd0);
        check_val("rst_ovf",   32'(o_ovf),   32'd0);
`ifdef GSIM_PACK_OVF_CNT_EN
        check_val("rst_ovf_cnt", 32'(o_ovf_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        tb_bcnt = 0;
        tb_idx  = 0;
        tb_wcnt = 0;
        tb_open = 1'b0;
        drop_lo = -1;
        drop_hi = -2;
    endtask

    // Monitor: compare each word the consumer accepts
    always @(negedge clk) begin
        if (!reset && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_e = exp_q.pop_front();
                check_val("word_data",  32'(o_data),  32'(exp_e[30:7]));
                check_val("word_index", 32'(o_index), 32'(exp_e[6:1]));
                check_val("word_last",  32'(o_last),  32'(exp_e[0]));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        mode     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        i_ready  = 1'b1;
        idle(3);
        check_val("init_valid", 32'(o_valid), 32'd0);
        check_val("init_data",  32'(o_data),  32'd0);
        check_val("init_ovf",   32'(o_ovf),   32'd0);
        reset = 1'b0;
        idle(2);

        // mode=0, 24 contiguous bytes; mode flips mid-frame and must be ignored
        mode = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 5) mode = 1'b1;
            send_byte(8'(i + 1));
        end
        mode = 1'b0;
        wait_drain("s1_drain", 50);
        check_val("s1_ovf", 32'(o_ovf), 32'd0);

        // gap mid-word, then latency of the completed word
        send_byte(8'hAA);
        idle(3);
        send_byte(8'hBB);
        send_byte(8'hCC);
        check_val("s3_lat_before", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        check_val("s3_lat_after", 32'(o_valid), 32'd1);
        check_val("s3_word", 32'(o_data), 32'h00AABBCC);
        for (int i = 0; i < 21; i++) send_byte(8'(8'hE0 + i));
        wait_drain("s3_drain", 50);

        // mode=1, consumer stalled for the first 40 bytes -> words 8..12 dropped
        mode    = 1'b1;
        i_ready = 1'b0;
        drop_lo = tb_wcnt + 8;
        drop_hi = tb_wcnt + 12;
        for (int i = 0; i < 192; i++) begin
            if (i == 40) i_ready = 1'b1;
            send_byte(8'(i));
            mode = 1'b0;
        end
        wait_drain("s2_drain", 200);
        check_val("s2_ovf", 32'(o_ovf), 32'd1);
        drop_lo = -1;
        drop_hi = -2;

        // next frame starts in S_FLUSH with 3 words queued and consumer stalled
        mode = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 18) i_ready = 1'b0;
            send_byte(8'(8'h30 + i));
        end
        for (int i = 0; i < 6; i++) send_byte(8'(8'h50 + i));
        check_val("s5_hold_valid", 32'(o_valid), 32'd1);
        check_val("s5_hold_data",  32'(o_data),  32'h003F4041);
        check_val("s5_hold_index", 32'(o_index), 32'd5);
        check_val("s5_hold_last",  32'(o_last),  32'd0);
        i_ready = 1'b1;
        for (int i = 6; i < 24; i++) send_byte(8'(8'h50 + i));
        wait_drain("s5_drain", 50);
        check_val("s5_ovf_sticky", 32'(o_ovf), 32'd1);

        // reset mid-frame and mid-word, then a clean frame
        for (int i = 0; i < 10; i++) send_byte(8'(8'h60 + i));
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'(8'h10 + i));
        @(posedge clk);
        #1;
        check_val("s4_first_data",  32'(o_data),  32'h00101112);
        check_val("s4_first_index", 32'(o_index), 32'd0);
        for (int i = 3; i < 24; i++) send_byte(8'(8'h10 + i));
        wait_drain("s4_drain", 50);
        check_val("s4_ovf", 32'(o_ovf), 32'd0);

`ifdef GSIM_PACK_OVF_CNT_EN
        // 308 words with the consumer stalled -> 300 drops, counter saturates
        do_reset();
        mode    = 1'b0;
        i_ready = 1'b0;
        drop_lo = 8;
        drop_hi = 307;
        for (int i = 0; i < 308 * 3; i++) send_byte(8'(i));
        idle(2);
        check_val("s6_ovf_cnt", 32'(o_ovf_cnt), 32'd255);
        check_val("s6_ovf", 32'(o_ovf), 32'd1);
        i_ready = 1'b1;
        wait_drain("s6_drain", 50);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
